// File: rtl/panel_pkg.sv
// Shared types, encodings and defaults for the TOY front-panel run controller.
package panel_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
    LOAD  = 3'd4,
    LOOK  = 3'd5
  } state_e;

  localparam logic [1:0] EXEC_IDLE = 2'd0;
  localparam logic [1:0] EXEC_RUN  = 2'd1;
  localparam logic [1:0] EXEC_STEP = 2'd2;

  localparam logic [7:0] PTR_RST_DEFAULT = 8'h10;

  // Field order is the button priority, highest first.
  typedef struct packed {
    logic stop;
    logic run;
    logic step;
    logic load;
    logic look;
    logic addr;
    logic pc;
  } btn_t;

  localparam btn_t BTN_NONE = 7'b000_0000;

  function automatic logic [1:0] exec_for(input state_e st);
    case (st)
      RUN:     exec_for = EXEC_RUN;
      STEP:    exec_for = EXEC_STEP;
      default: exec_for = EXEC_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/panel_ctrl_if.sv
// Panel memory request port: the controller is master, the core memory is slave.
interface panel_ctrl_if;
  logic        val;
  logic        wen;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        rdy;
  logic [15:0] rdata;

  modport master (output val, wen, addr, wdata, input rdy, rdata);
  modport slave  (input val, wen, addr, wdata, output rdy, rdata);
endinterface

// File: rtl/panel_btn_arb.sv
// Filters button pulses by what the current state accepts, then keeps only the
// highest-priority survivor as a one-hot command.
module panel_btn_arb import panel_pkg::*; (
  input  state_e state,
  input  btn_t   btn,
  output btn_t   cmd
);

  btn_t legal_s;

  // State-legal filter: IDLE takes everything but stop, RUN/STEP take only stop.
  always_comb begin
    legal_s = BTN_NONE;
    case (state)
      IDLE: begin
        legal_s      = btn;
        legal_s.stop = 1'b0;
      end
      RUN, STEP: legal_s.stop = btn.stop;
      default:   legal_s = BTN_NONE;
    endcase
  end

  // Priority encoder: stop > run > step > load > look > addr > pc.
  always_comb begin
    cmd = BTN_NONE;
    if (legal_s.stop) begin
      cmd.stop = 1'b1;
    end else if (legal_s.run) begin
      cmd.run = 1'b1;
    end else if (legal_s.step) begin
      cmd.step = 1'b1;
    end else if (legal_s.load) begin
      cmd.load = 1'b1;
    end else if (legal_s.look) begin
      cmd.look = 1'b1;
    end else if (legal_s.addr) begin
      cmd.addr = 1'b1;
    end else if (legal_s.pc) begin
      cmd.pc = 1'b1;
    end else begin
      cmd = BTN_NONE;
    end
  end

endmodule

// File: rtl/panel_ctrl.sv
// TOY front-panel run controller: core run/step/drain control plus panel load/look
// memory accesses. Define PANEL_AUTOINC_EN to post-increment the pointer per access.
module panel_ctrl import panel_pkg::*; #(
  parameter int unsigned DRAIN_TMO = 255,
  parameter logic [7:0]  PTR_RST   = PTR_RST_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         btn_run_i,
  input  logic         btn_stop_i,
  input  logic         btn_step_i,
  input  logic         btn_load_i,
  input  logic         btn_look_i,
  input  logic         btn_addr_i,
  input  logic         btn_pc_i,
  input  logic [7:0]   sw_addr_i,
  input  logic [15:0]  sw_data_i,
  output logic [1:0]   cpu_exec_o,
  output logic         pc_wen_o,
  output logic [7:0]   pc_o,
  output logic         core_rst_no,
  input  logic         cpu_halt_i,
  input  logic         cpu_done_i,
  input  logic         instr_val_i,
  panel_ctrl_if.master mem,
  output logic [7:0]   disp_addr_o,
  output logic [15:0]  disp_data_o,
  output logic         running_o,
  output logic         halted_o
);

  localparam logic [15:0] TMO_CNT  = 16'(DRAIN_TMO);
  localparam logic [15:0] TMO_LAST = 16'(DRAIN_TMO - 32'd1);

  state_e       state_r, state_s;
  btn_t         btn_s, cmd_s;
  logic [15:0]  cnt_r, cnt_s;
  logic [7:0]   ptr_r, ptr_s, pc_r, pc_s, mem_addr_r, mem_addr_s, disp_addr_r, disp_addr_s;
  logic [15:0]  mem_wdata_r, mem_wdata_s, disp_data_r, disp_data_s;
  logic [1:0]   cpu_exec_r;
  logic         pc_wen_r, pc_wen_s, core_rst_r, core_rst_s;
  logic         mem_val_r, mem_val_s, mem_wen_r, mem_wen_s;
  logic         running_r, running_s, halted_r, halted_s;

  assign btn_s = {btn_stop_i, btn_run_i, btn_step_i, btn_load_i,
                  btn_look_i, btn_addr_i, btn_pc_i};

  panel_btn_arb u_arb (
    .state (state_r),
    .btn   (btn_s),
    .cmd   (cmd_s)
  );

  // Next-state and next-output logic for the run/drain/access controller.
  always_comb begin
    state_s     = state_r;
    cnt_s       = 16'd0;
    ptr_s       = ptr_r;
    pc_s        = pc_r;
    pc_wen_s    = 1'b0;
    core_rst_s  = 1'b1;
    mem_val_s   = mem_val_r;
    mem_wen_s   = mem_wen_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    disp_addr_s = disp_addr_r;
    disp_data_s = disp_data_r;
    running_s   = running_r;
    halted_s    = halted_r;
    case (state_r)
      IDLE: begin
        if (cmd_s.run) begin
          state_s   = RUN;
          running_s = 1'b1;
          halted_s  = 1'b0;
        end else if (cmd_s.step) begin
          state_s  = STEP;
          halted_s = 1'b0;
        end else if (cmd_s.load || cmd_s.look) begin
          state_s     = cmd_s.load ? LOAD : LOOK;
          mem_val_s   = 1'b1;
          mem_wen_s   = cmd_s.load;
          mem_addr_s  = ptr_r;
          mem_wdata_s = sw_data_i;
        end else if (cmd_s.addr) begin
          ptr_s       = sw_addr_i;
          disp_addr_s = sw_addr_i;
        end else if (cmd_s.pc) begin
          pc_wen_s = 1'b1;
          pc_s     = ptr_r;
        end else begin
          state_s = IDLE;
        end
      end
      RUN, STEP: begin
        if (cpu_halt_i) begin
          state_s  = DRAIN;
          halted_s = 1'b1;
        end else if (cmd_s.stop || ((state_r == STEP) && instr_val_i)) begin
          state_s = DRAIN;
        end else begin
          state_s = state_r;
        end
      end
      DRAIN: begin
        // The flush pulse occupies the cycle where the counter equals DRAIN_TMO.
        if (cpu_done_i || (cnt_r == TMO_CNT)) begin
          state_s   = IDLE;
          running_s = 1'b0;
        end else begin
          cnt_s = cnt_r + 16'd1;
          if (cnt_r == TMO_LAST) begin
            core_rst_s = 1'b0;
          end else begin
            core_rst_s = 1'b1;
          end
        end
      end
      LOAD, LOOK: begin
        if (mem_val_r && mem.rdy) begin
          state_s     = IDLE;
          mem_val_s   = 1'b0;
          disp_addr_s = mem_addr_r;
          disp_data_s = mem_wen_r ? mem_wdata_r : mem.rdata;
`ifdef PANEL_AUTOINC_EN
          ptr_s = ptr_r + 8'd1;
`else
          ptr_s = ptr_r;
`endif
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s   = IDLE;
        mem_val_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      cnt_r       <= 16'd0;
      ptr_r       <= PTR_RST;
      pc_r        <= 8'd0;
      pc_wen_r    <= 1'b0;
      core_rst_r  <= 1'b1;
      cpu_exec_r  <= EXEC_IDLE;
      mem_val_r   <= 1'b0;
      mem_wen_r   <= 1'b0;
      mem_addr_r  <= 8'd0;
      mem_wdata_r <= 16'd0;
      disp_addr_r <= PTR_RST;
      disp_data_r <= 16'd0;
      running_r   <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      ptr_r       <= ptr_s;
      pc_r        <= pc_s;
      pc_wen_r    <= pc_wen_s;
      core_rst_r  <= core_rst_s;
      cpu_exec_r  <= exec_for(state_s);
      mem_val_r   <= mem_val_s;
      mem_wen_r   <= mem_wen_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      disp_addr_r <= disp_addr_s;
      disp_data_r <= disp_data_s;
      running_r   <= running_s;
      halted_r    <= halted_s;
    end
  end

  assign cpu_exec_o  = cpu_exec_r;
  assign pc_wen_o    = pc_wen_r;
  assign pc_o        = pc_r;
  assign core_rst_no = core_rst_r;
  assign mem.val     = mem_val_r;
  assign mem.wen     = mem_wen_r;
  assign mem.addr    = mem_addr_r;
  assign mem.wdata   = mem_wdata_r;
  assign disp_addr_o = disp_addr_r;
  assign disp_data_o = disp_data_r;
  assign running_o   = running_r;
  assign halted_o    = halted_r;

endmodule

// File: tb/tb_panel_ctrl.sv
// Directed self-checking bench for panel_ctrl (DRAIN_TMO=8); expectations follow
// PANEL_AUTOINC_EN when it is defined for the build.
module tb_panel_ctrl;

`ifdef PANEL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        btn_run_i, btn_stop_i, btn_step_i, btn_load_i, btn_look_i, btn_addr_i, btn_pc_i;
  logic [7:0]  sw_addr_i;
  logic [15:0] sw_data_i;
  logic [1:0]  cpu_exec_o;
  logic        pc_wen_o;
  logic [7:0]  pc_o;
  logic        core_rst_no;
  logic        cpu_halt_i, cpu_done_i, instr_val_i;
  logic [7:0]  disp_addr_o;
  logic [15:0] disp_data_o;
  logic        running_o, halted_o;
  int          n_tests = 0;
  int          n_fail  = 0;

  panel_ctrl_if mem_bus ();

  panel_ctrl #(.DRAIN_TMO(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .btn_run_i(btn_run_i), .btn_stop_i(btn_stop_i), .btn_step_i(btn_step_i),
    .btn_load_i(btn_load_i), .btn_look_i(btn_look_i), .btn_addr_i(btn_addr_i),
    .btn_pc_i(btn_pc_i), .sw_addr_i(sw_addr_i), .sw_data_i(sw_data_i),
    .cpu_exec_o(cpu_exec_o), .pc_wen_o(pc_wen_o), .pc_o(pc_o), .core_rst_no(core_rst_no),
    .cpu_halt_i(cpu_halt_i), .cpu_done_i(cpu_done_i), .instr_val_i(instr_val_i),
    .mem(mem_bus.master), .disp_addr_o(disp_addr_o), .disp_data_o(disp_data_o),
    .running_o(running_o), .halted_o(halted_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_btns();
    btn_run_i = 1'b0; btn_stop_i = 1'b0; btn_step_i = 1'b0; btn_load_i = 1'b0;
    btn_look_i = 1'b0; btn_addr_i = 1'b0; btn_pc_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    n_tests++;
    if ({cpu_exec_o, pc_wen_o, pc_o, core_rst_no} !== {2'd0, 1'b0, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL reset_core: got %h/%b/%h/%b want 0/0/00/1", cpu_exec_o, pc_wen_o, pc_o, core_rst_no);
    end
    n_tests++;
    if ({mem_bus.val, mem_bus.wen, mem_bus.addr, mem_bus.wdata} !== {1'b0, 1'b0, 8'h00, 16'h0000}) begin
      n_fail++; $display("FAIL reset_mem: got %b/%b/%h/%h want 0/0/00/0000", mem_bus.val, mem_bus.wen, mem_bus.addr, mem_bus.wdata);
    end
    n_tests++;
    if ({disp_addr_o, disp_data_o, running_o, halted_o} !== {8'h10, 16'h0000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_disp: got %h/%h/%b/%b want 10/0000/0/0", disp_addr_o, disp_data_o, running_o, halted_o);
    end
  endtask

  task automatic test_load();
    sw_addr_i = 8'h20; btn_addr_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if (disp_addr_o !== 8'h20) begin n_fail++; $display("FAIL load_addr_btn: got %h want 20", disp_addr_o); end
    sw_data_i = 16'h1234; mem_bus.rdy = 1'b1; btn_load_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if ({mem_bus.val, mem_bus.wen, mem_bus.addr, mem_bus.wdata} !== {1'b1, 1'b1, 8'h20, 16'h1234}) begin
      n_fail++; $display("FAIL load_req: got %b/%b/%h/%h want 1/1/20/1234", mem_bus.val, mem_bus.wen, mem_bus.addr, mem_bus.wdata);
    end
    tick();
    n_tests++;
    if ({mem_bus.val, disp_addr_o, disp_data_o} !== {1'b0, 8'h20, 16'h1234}) begin
      n_fail++; $display("FAIL load_done: got %b/%h/%h want 0/20/1234", mem_bus.val, disp_addr_o, disp_data_o);
    end
    mem_bus.rdy = 1'b0; btn_pc_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if ({pc_wen_o, pc_o} !== {1'b1, (AUTOINC ? 8'h21 : 8'h20)}) begin
      n_fail++; $display("FAIL load_ptr_pc: got %b/%h want 1/%h", pc_wen_o, pc_o, (AUTOINC ? 8'h21 : 8'h20));
    end
    tick();
    n_tests++;
    if (pc_wen_o !== 1'b0) begin n_fail++; $display("FAIL pc_wen_pulse: got %b want 0", pc_wen_o); end
  endtask

  task automatic test_look();
    sw_addr_i = 8'h20; btn_addr_i = 1'b1; tick(); clear_btns();
    mem_bus.rdy = 1'b0; mem_bus.rdata = 16'hBEEF; btn_look_i = 1'b1; tick(); clear_btns();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ({mem_bus.val, mem_bus.wen, mem_bus.addr} !== {1'b1, 1'b0, 8'h20}) begin
        n_fail++; $display("FAIL look_wait%0d: got %b/%b/%h want 1/0/20", i, mem_bus.val, mem_bus.wen, mem_bus.addr);
      end
      btn_run_i = (i == 1);
      tick();
      clear_btns();
    end
    n_tests++;
    if ({mem_bus.val, mem_bus.addr} !== {1'b1, 8'h20}) begin
      n_fail++; $display("FAIL look_cycle4: got %b/%h want 1/20", mem_bus.val, mem_bus.addr);
    end
    mem_bus.rdy = 1'b1; tick(); mem_bus.rdy = 1'b0;
    n_tests++;
    if ({mem_bus.val, disp_addr_o, disp_data_o} !== {1'b0, 8'h20, 16'hBEEF}) begin
      n_fail++; $display("FAIL look_done: got %b/%h/%h want 0/20/beef", mem_bus.val, disp_addr_o, disp_data_o);
    end
    tick();
    n_tests++;
    if (cpu_exec_o !== 2'd0) begin n_fail++; $display("FAIL look_drop_run: got %0d want 0", cpu_exec_o); end
  endtask

  task automatic test_run_halt();
    btn_run_i = 1'b1; tick(); clear_btns();
    for (int k = 1; k <= 10; k++) begin
      n_tests++;
      if ({cpu_exec_o, running_o} !== {2'd1, 1'b1}) begin
        n_fail++; $display("FAIL run_cycle%0d: got %0d/%b want 1/1", k, cpu_exec_o, running_o);
      end
      cpu_halt_i = (k == 10);
      tick();
    end
    cpu_halt_i = 1'b0;
    n_tests++;
    if ({cpu_exec_o, halted_o, running_o} !== {2'd0, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL run_halt: got %0d/%b/%b want 0/1/1", cpu_exec_o, halted_o, running_o);
    end
    tick(); tick();
    cpu_done_i = 1'b1; tick(); cpu_done_i = 1'b0;
    n_tests++;
    if ({cpu_exec_o, halted_o, running_o} !== {2'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL run_drained: got %0d/%b/%b want 0/1/0", cpu_exec_o, halted_o, running_o);
    end
  endtask

  task automatic test_step();
    btn_step_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if ({cpu_exec_o, halted_o} !== {2'd2, 1'b0}) begin
      n_fail++; $display("FAIL step_enter: got %0d/%b want 2/0", cpu_exec_o, halted_o);
    end
    tick();
    n_tests++;
    if (cpu_exec_o !== 2'd2) begin n_fail++; $display("FAIL step_cycle2: got %0d want 2", cpu_exec_o); end
    tick();
    n_tests++;
    if (cpu_exec_o !== 2'd2) begin n_fail++; $display("FAIL step_cycle3: got %0d want 2", cpu_exec_o); end
    instr_val_i = 1'b1; tick(); instr_val_i = 1'b0;
    n_tests++;
    if (cpu_exec_o !== 2'd0) begin n_fail++; $display("FAIL step_retire: got %0d want 0", cpu_exec_o); end
    btn_run_i = 1'b1; cpu_done_i = 1'b1; tick(); clear_btns(); cpu_done_i = 1'b0;
    tick();
    n_tests++;
    if (cpu_exec_o !== 2'd0) begin n_fail++; $display("FAIL drain_drop_run: got %0d want 0", cpu_exec_o); end
  endtask

  task automatic test_stop_wins();
    btn_step_i = 1'b1; tick(); clear_btns();
    btn_stop_i = 1'b1; btn_run_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if (cpu_exec_o !== 2'd0) begin n_fail++; $display("FAIL stop_wins_drain: got %0d want 0", cpu_exec_o); end
    cpu_done_i = 1'b1; tick(); cpu_done_i = 1'b0;
    tick();
    n_tests++;
    if ({cpu_exec_o, running_o} !== {2'd0, 1'b0}) begin
      n_fail++; $display("FAIL stop_wins_idle: got %0d/%b want 0/0", cpu_exec_o, running_o);
    end
  endtask

  task automatic test_drain_tmo();
    btn_run_i = 1'b1; tick(); clear_btns();
    btn_stop_i = 1'b1; tick(); clear_btns();
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (core_rst_no !== 1'b1) begin n_fail++; $display("FAIL tmo_early%0d: got %b want 1", k, core_rst_no); end
      tick();
    end
    n_tests++;
    if (core_rst_no !== 1'b0) begin n_fail++; $display("FAIL tmo_flush: got %b want 0", core_rst_no); end
    tick();
    n_tests++;
    if ({core_rst_no, running_o} !== {1'b1, 1'b0}) begin
      n_fail++; $display("FAIL tmo_after: got %b/%b want 1/0", core_rst_no, running_o);
    end
    btn_run_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if (cpu_exec_o !== 2'd1) begin n_fail++; $display("FAIL tmo_idle_run: got %0d want 1", cpu_exec_o); end
    btn_stop_i = 1'b1; tick(); clear_btns();
    cpu_done_i = 1'b1; tick(); cpu_done_i = 1'b0;
  endtask

  task automatic test_wrap();
    mem_bus.rdy = 1'b1;
    sw_addr_i = 8'hFF; btn_addr_i = 1'b1; tick(); clear_btns();
    sw_data_i = 16'hAAAA; btn_load_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if ({mem_bus.val, mem_bus.addr, mem_bus.wdata} !== {1'b1, 8'hFF, 16'hAAAA}) begin
      n_fail++; $display("FAIL wrap_first: got %b/%h/%h want 1/ff/aaaa", mem_bus.val, mem_bus.addr, mem_bus.wdata);
    end
    tick();
    sw_data_i = 16'h5555; btn_load_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if ({mem_bus.val, mem_bus.addr} !== {1'b1, (AUTOINC ? 8'h00 : 8'hFF)}) begin
      n_fail++; $display("FAIL wrap_second: got %b/%h want 1/%h", mem_bus.val, mem_bus.addr, (AUTOINC ? 8'h00 : 8'hFF));
    end
    tick();
    btn_pc_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if ({pc_wen_o, pc_o} !== {1'b1, (AUTOINC ? 8'h01 : 8'hFF)}) begin
      n_fail++; $display("FAIL wrap_pc: got %b/%h want 1/%h", pc_wen_o, pc_o, (AUTOINC ? 8'h01 : 8'hFF));
    end
    sw_addr_i = 8'h33; btn_addr_i = 1'b1; btn_pc_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if ({pc_wen_o, disp_addr_o} !== {1'b0, 8'h33}) begin
      n_fail++; $display("FAIL prio_addr_pc: got %b/%h want 0/33", pc_wen_o, disp_addr_o);
    end
    sw_addr_i = 8'h44; btn_look_i = 1'b1; btn_addr_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if ({mem_bus.val, mem_bus.wen, mem_bus.addr} !== {1'b1, 1'b0, 8'h33}) begin
      n_fail++; $display("FAIL prio_look_addr: got %b/%b/%h want 1/0/33", mem_bus.val, mem_bus.wen, mem_bus.addr);
    end
    tick();
    mem_bus.rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    btn_load_i = 1'b1; tick(); clear_btns();
    n_tests++;
    if (mem_bus.val !== 1'b1) begin n_fail++; $display("FAIL mid_req: got %b want 1", mem_bus.val); end
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    n_tests++;
    if ({mem_bus.val, disp_addr_o} !== {1'b0, 8'h10}) begin
      n_fail++; $display("FAIL mid_reset: got %b/%h want 0/10", mem_bus.val, disp_addr_o);
    end
    tick();
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_btns();
    sw_addr_i = 8'h00; sw_data_i = 16'h0000;
    cpu_halt_i = 1'b0; cpu_done_i = 1'b0; instr_val_i = 1'b0;
    mem_bus.rdy = 1'b0; mem_bus.rdata = 16'h0000;
    test_reset();
    test_load();
    test_look();
    test_run_halt();
    test_step();
    test_stop_wins();
    test_drain_tmo();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
